i2c_sub_sequencer: RTL and testbench

Bus-phase controller for the I2C subordinate interface. It synchronises the raw SCL/SDA pins into the system clock domain, detects START/STOP, and counts bits. It sequences the address phase of the address checker, drives ACK and read data onto SDA, and hands write bytes to the register side. It sits between the pad logic and the address checker / register file and is the only block that drives the SDA open-drain enable.

---
 rtl/i2c_sub_sequencer.sv | 178 +++++++++++++++++
 tb/tb_i2c_sub_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sub_sequencer.sv
// I2C subordinate bus-phase sequencer: sync SCL/SDA, detect START/STOP, count bits, drive ACK/read data.
// Pin-to-response latency SYNC_STAGES+1 clk; no backpressure, SCL timing is dictated by the master.
module i2c_sub_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       addr_match,
  input  logic       rw_bit,
  input  logic [7:0] tx_data,
  output logic       sda_oe,
  output logic       read_address,
  output logic [3:0] clock_count,
  output logic       start_det,
  output logic       stop_det,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WR_DATA   = 3'd3;
  localparam logic [2:0] WR_ACK    = 3'd4;
  localparam logic [2:0] RD_DATA   = 3'd5;
  localparam logic [2:0] RD_ACK    = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d;
  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_cond, stop_cond;
  logic [2:0] state;
  logic [7:0] shift;
  logic match_q, rw_q, nack_q, seen_rise;

  // Synchronisers reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_d;
  assign scl_fall   = ~scl_s & scl_d;
  assign start_cond = scl_s & sda_d & ~sda_s;
  assign stop_cond  = scl_s & ~sda_d & sda_s;

  assign read_address = (state == ADDR);
  assign busy         = (state != IDLE);

  // seen_rise gates bit counting so the SCL fall that ends a START is not counted as a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sda_oe      <= 1'b0;
      clock_count <= 4'd0;
      start_det   <= 1'b0;
      stop_det    <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_req      <= 1'b0;
      shift       <= 8'h00;
      match_q     <= 1'b0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b1;
      seen_rise   <= 1'b0;
    end else begin
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      if (start_cond) begin
        start_det   <= 1'b1;
        clock_count <= 4'd0;
        sda_oe      <= 1'b0;
        seen_rise   <= 1'b0;
        state       <= ADDR;
      end else if (stop_cond) begin
        stop_det  <= 1'b1;
        sda_oe    <= 1'b0;
        seen_rise <= 1'b0;
        state     <= IDLE;
      end else if (scl_rise && state != IDLE && state != WAIT_STOP) begin
        seen_rise <= 1'b1;
        case (state)
          ADDR: if (clock_count == 4'd7) begin
            match_q <= addr_match;
            rw_q    <= rw_bit;
          end
          WR_DATA: shift  <= {shift[6:0], sda_s};
          RD_ACK:  nack_q <= sda_s;
          default: ;
        endcase
      end else if (scl_fall && seen_rise) begin
        seen_rise <= 1'b0;
        case (state)
          ADDR: begin
            if (clock_count == 4'd7) begin
              clock_count <= 4'd8;
              sda_oe      <= match_q;
              state       <= match_q ? ADDR_ACK : WAIT_STOP;
            end else begin
              clock_count <= clock_count + 4'd1;
            end
          end
          ADDR_ACK: begin
            clock_count <= 4'd0;
            if (rw_q) begin
              tx_req <= 1'b1;
              sda_oe <= ~tx_data[7];
              shift  <= {tx_data[6:0], 1'b0};
              state  <= RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (clock_count == 4'd7) begin
              clock_count <= 4'd8;
              rx_data     <= shift;
              rx_valid    <= 1'b1;
              sda_oe      <= 1'b1;
              state       <= WR_ACK;
            end else begin
              clock_count <= clock_count + 4'd1;
            end
          end
          WR_ACK: begin
            clock_count <= 4'd0;
            sda_oe      <= 1'b0;
            state       <= WR_DATA;
          end
          RD_DATA: begin
            if (clock_count == 4'd7) begin
              clock_count <= 4'd8;
              sda_oe      <= 1'b0;
              state       <= RD_ACK;
            end else begin
              clock_count <= clock_count + 4'd1;
              sda_oe      <= ~shift[7];
              shift       <= {shift[6:0], 1'b0};
            end
          end
          RD_ACK: begin
            clock_count <= 4'd0;
            if (!nack_q) begin
              tx_req <= 1'b1;
              sda_oe <= ~tx_data[7];
              shift  <= {tx_data[6:0], 1'b0};
              state  <= RD_DATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_sub_sequencer.sv
// Directed bench: a bit-banged I2C master on a wired-AND SDA line, with byte scoreboards for rx and tx data.
module tb_i2c_sub_sequencer;
  localparam int Q = 6;
  localparam int H = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic scl = 1'b1, sda_m = 1'b1;
  logic addr_match = 1'b0, rw_bit = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic sda_line;
  logic sda_oe, read_address, start_det, stop_det, rx_valid, tx_req, busy;
  logic [3:0] clock_count;
  logic [7:0] rx_data;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_sub_sequencer #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line),
    .addr_match(addr_match), .rw_bit(rw_bit), .tx_data(tx_data),
    .sda_oe(sda_oe), .read_address(read_address), .clock_count(clock_count),
    .start_det(start_det), .stop_det(stop_det), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_req(tx_req), .busy(busy)
  );

  int checks = 0, errors = 0;
  int n_start = 0, n_stop = 0, n_rxv = 0, n_txr = 0, n_ra = 0;
  logic scl_prev = 1'b1;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [8:0] rx_exp;
  logic b_line, b_oe;
  logic [3:0] b_cc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (tx_req) n_txr++;
    if (scl && !scl_prev && read_address) n_ra++;
    scl_prev = scl;
    if (rx_valid) begin
      n_rxv++;
      rx_exp = (rx_q.size() > 0) ? {1'b1, rx_q.pop_front()} : 9'h000;
      chk("rx_data", {1'b1, rx_data}, rx_exp);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic clk_bit(input logic b);
    sda_m = b; wait_clk(Q);
    scl = 1'b1; wait_clk(H/2);
    b_line = sda_line; b_oe = sda_oe; b_cc = clock_count;
    wait_clk(H/2);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) clk_bit(v[i]);
  endtask

  task automatic read_byte(output logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1);
      v[i] = b_line;
    end
  endtask

  initial begin
    int s_start, s_stop, s_rxv, s_txr, s_ra;
    logic [7:0] rd;

    // Reset values
    wait_clk(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_read_address", read_address, 0);
    chk("rst_clock_count", clock_count, 0);
    chk("rst_start_stop", {start_det, stop_det}, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_tx_pulses", {rx_valid, tx_req}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_clk(4);

    // Matched write of 0xA5
    addr_match = 1'b1; rw_bit = 1'b0;
    s_start = n_start; s_stop = n_stop; s_rxv = n_rxv; s_ra = n_ra;
    bus_start();
    chk("wr_start_det", n_start - s_start, 1);
    chk("wr_read_address", read_address, 1);
    chk("wr_cc_after_start", clock_count, 0);
    send_byte({7'b1100110, 1'b0});
    clk_bit(1'b1);
    chk("wr_ra_rises", n_ra - s_ra, 8);
    chk("wr_addr_ack_oe", b_oe, 1);
    chk("wr_addr_ack_line", b_line, 0);
    chk("wr_ack_cc", b_cc, 8);
    rx_q.push_back(8'hA5);
    send_byte(8'hA5);
    clk_bit(1'b1);
    chk("wr_data_ack_oe", b_oe, 1);
    bus_stop();
    chk("wr_stop_det", n_stop - s_stop, 1);
    chk("wr_rx_valid_cnt", n_rxv - s_rxv, 1);
    chk("wr_rx_data_hold", rx_data, 8'hA5);
    chk("wr_busy_end", busy, 0);

    // Unmatched address: no ACK, data ignored
    addr_match = 1'b0;
    s_rxv = n_rxv;
    bus_start();
    send_byte({7'b1010101, 1'b0});
    clk_bit(1'b1);
    chk("nm_ack_oe", b_oe, 0);
    chk("nm_wait_stop", {busy, read_address}, 2'b10);
    send_byte(8'h5A);
    clk_bit(1'b1);
    chk("nm_data_oe", b_oe, 0);
    chk("nm_no_rx", n_rxv - s_rxv, 0);
    bus_stop();
    chk("nm_busy_end", busy, 0);

    // Read of 0x3C (ACK) then 0xC3 (NACK)
    addr_match = 1'b1; rw_bit = 1'b1;
    tx_data = 8'h3C; tx_q.push_back(8'h3C);
    s_txr = n_txr;
    bus_start();
    send_byte({7'b1100110, 1'b1});
    clk_bit(1'b1);
    chk("rd_addr_ack_oe", b_oe, 1);
    chk("rd_tx_req_first", n_txr - s_txr, 1);
    tx_data = 8'hC3; tx_q.push_back(8'hC3);
    read_byte(rd);
    chk("rd_byte0", rd, tx_q.pop_front());
    clk_bit(1'b0);
    read_byte(rd);
    chk("rd_byte1", rd, tx_q.pop_front());
    clk_bit(1'b1);
    chk("rd_tx_req_total", n_txr - s_txr, 2);
    chk("rd_nack_oe", sda_oe, 0);
    chk("rd_wait_stop", {busy, read_address}, 2'b10);
    bus_stop();
    chk("rd_busy_end", busy, 0);

    // Two write bytes, then repeated START with a new address
    rw_bit = 1'b0;
    bus_start();
    send_byte({7'b1100110, 1'b0});
    clk_bit(1'b1);
    rx_q.push_back(8'h11); send_byte(8'h11); clk_bit(1'b1);
    rx_q.push_back(8'h22); send_byte(8'h22); clk_bit(1'b1);
    s_start = n_start; s_stop = n_stop;
    bus_start();
    chk("rs_start_det", n_start - s_start, 1);
    chk("rs_no_stop", n_stop - s_stop, 0);
    chk("rs_cc", clock_count, 0);
    chk("rs_read_address", read_address, 1);
    send_byte({7'b0110011, 1'b0});
    clk_bit(1'b1);
    chk("rs_addr_ack_oe", b_oe, 1);
    bus_stop();

    // STOP after four write bits
    bus_start();
    send_byte({7'b1100110, 1'b0});
    clk_bit(1'b1);
    s_stop = n_stop; s_rxv = n_rxv;
    clk_bit(1'b1); clk_bit(1'b0); clk_bit(1'b1); clk_bit(1'b1);
    chk("ms_cc_mid", clock_count, 4);
    bus_stop();
    chk("ms_stop_det", n_stop - s_stop, 1);
    chk("ms_idle", busy, 0);
    chk("ms_no_rx", n_rxv - s_rxv, 0);
    chk("ms_oe", sda_oe, 0);

    // Reset while ACK is being driven
    bus_start();
    send_byte({7'b1100110, 1'b0});
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1; wait_clk(H/2);
    chk("ar_oe_before", sda_oe, 1);
    #2 rst_n = 1'b0;
    #1 chk("ar_oe_async", sda_oe, 0);
    chk("ar_outputs", {read_address, clock_count, start_det, stop_det, rx_valid, tx_req, busy}, 0);
    chk("ar_rx_data", rx_data, 8'h00);
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    s_start = n_start;
    bus_start();
    chk("ar_restart_det", n_start - s_start, 1);
    send_byte({7'b1100110, 1'b0});
    clk_bit(1'b1);
    chk("ar_addr_ack_oe", b_oe, 1);
    rx_q.push_back(8'h77);
    send_byte(8'h77);
    clk_bit(1'b1);
    bus_stop();
    chk("ar_busy_end", busy, 0);
    chk("rx_q_drained", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
